// File: rtl/parametric_store_queue.sv
// Parametric in-order store queue for the memory functional unit.
// Stores are allocated at the tail at dispatch. Their address arrives on the address port and their
// data arrives either at allocation or by CDB snooping. The ROB commits them in order (cmt pointer),
// and committed stores drain from the head to the memory port. Loads are checked against older stores
// for forwarding or stall. A flush discards everything past the commit pointer.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   alloc_*                     dispatch-side allocation; alloc_idx = tail pointer
//   addr_valid/idx/value        effective address write for one entry
//   cdb, cdb_valid              result bus snoop {tag, data}
//   cmt_valid, cmt_id           in-order commit from the ROB; cmt_err is sticky on mismatch
//   flush                       discard uncommitted entries
//   ld_*                        combinational load lookup (hit / stall / miss)
//   o_*, o_ready                head store to memory
//   count                       occupied entries (head..tail)
module parametric_store_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RSV_ID_W = 5,
  parameter int unsigned INSTR_W  = 6,
  localparam int unsigned PTR_W   = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [RSV_ID_W-1:0]        alloc_rob_id,
  input  logic [INSTR_W-1:0]         alloc_opcode,
  input  logic [DATA_W-1:0]          alloc_data,
  input  logic [RSV_ID_W-1:0]        alloc_dtag,
  input  logic                       alloc_dfill,
  output logic [PTR_W:0]             alloc_idx,
  input  logic                       addr_valid,
  input  logic [PTR_W:0]             addr_idx,
  input  logic [DATA_W-1:0]          addr_value,
  input  logic [RSV_ID_W+DATA_W-1:0] cdb,
  input  logic                       cdb_valid,
  input  logic                       cmt_valid,
  input  logic [RSV_ID_W-1:0]        cmt_id,
  input  logic                       flush,
  input  logic                       ld_valid,
  input  logic [DATA_W-1:0]          ld_addr,
  input  logic [PTR_W:0]             ld_age,
  output logic                       ld_hit,
  output logic [DATA_W-1:0]          ld_data,
  output logic                       ld_stall,
  output logic                       o_valid,
  output logic [RSV_ID_W-1:0]        o_rob_id,
  output logic [INSTR_W-1:0]         o_opcode,
  output logic [DATA_W-1:0]          o_address,
  output logic [DATA_W-1:0]          o_data,
  input  logic                       o_ready,
  output logic [PTR_W:0]             count,
  output logic                       cmt_err
);

  logic [PTR_W:0]        head_q, cmt_q, tail_q;
  logic [PTR_W:0]        head_d, cmt_d, tail_d;
  logic [DEPTH-1:0]      valid_q, addr_rdy_q, data_rdy_q;
  logic [RSV_ID_W-1:0]   rob_q  [DEPTH];
  logic [RSV_ID_W-1:0]   dtag_q [DEPTH];
  logic [INSTR_W-1:0]    op_q   [DEPTH];
  logic [DATA_W-1:0]     addr_q [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];
  logic                  cmt_err_q;

  logic [PTR_W-1:0]      hs;
  logic                  full, do_alloc, alloc_cap, cmt_ok, pop, addr_ok;
  logic [RSV_ID_W-1:0]   cdb_tag;
  logic [DATA_W-1:0]     cdb_data;
  logic [PTR_W:0]        addr_off, kill_span;
  logic [DEPTH-1:0]      kill;

  assign hs        = head_q[PTR_W-1:0];
  assign cdb_tag   = cdb[RSV_ID_W+DATA_W-1:DATA_W];
  assign cdb_data  = cdb[DATA_W-1:0];
  assign count     = tail_q - head_q;
  assign full      = (tail_q ^ head_q) == {1'b1, {PTR_W{1'b0}}};
  assign alloc_ready = !full && !flush;
  assign alloc_idx = tail_q;
  assign do_alloc  = alloc_valid && alloc_ready;
  assign alloc_cap = cdb_valid && (cdb_tag == alloc_dtag) && !alloc_dfill;
  assign cmt_ok    = cmt_valid && (cmt_q != tail_q) && (rob_q[cmt_q[PTR_W-1:0]] == cmt_id);
  assign cmt_err   = cmt_err_q;

  assign o_valid   = (head_q != cmt_q) && addr_rdy_q[hs] && data_rdy_q[hs];
  assign o_rob_id  = rob_q[hs];
  assign o_opcode  = op_q[hs];
  assign o_address = addr_q[hs];
  assign o_data    = data_q[hs];
  assign pop       = o_valid && o_ready;

  // Offset from head must fall inside head..tail; this also rejects a stale wrap bit.
  assign addr_off  = addr_idx - head_q;
  assign addr_ok   = addr_valid && (addr_off < count) && valid_q[addr_idx[PTR_W-1:0]];

  assign head_d    = head_q + (PTR_W+1)'(pop);
  assign cmt_d     = cmt_q + (PTR_W+1)'(cmt_ok);
  assign tail_d    = flush ? cmt_d : tail_q + (PTR_W+1)'(do_alloc);

  // Slots between the post-commit pointer and the tail are discarded on flush.
  assign kill_span = tail_q - cmt_d;
  always_comb begin
    kill = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      kill[i] = flush && ({1'b0, PTR_W'(PTR_W'(i) - cmt_d[PTR_W-1:0])} < kill_span);
    end
  end

  // Walk oldest to youngest; the last deciding entry is the youngest older store.
  logic                found, f_rdy;
  logic [DATA_W-1:0]   f_data;
  logic [PTR_W:0]      age_off;
  logic [PTR_W-1:0]    ls;
  always_comb begin
    found   = 1'b0;
    f_rdy   = 1'b0;
    f_data  = '0;
    ls      = '0;
    age_off = ld_age - head_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      ls = hs + PTR_W'(k);
      if (((PTR_W+1)'(k) < age_off) && ((PTR_W+1)'(k) < count)) begin
        if (!addr_rdy_q[ls] || (addr_q[ls] == ld_addr)) begin
          found  = 1'b1;
          f_rdy  = addr_rdy_q[ls] && data_rdy_q[ls];
          f_data = data_q[ls];
        end
      end
    end
    ld_hit   = ld_valid && found && f_rdy;
    ld_stall = ld_valid && found && !f_rdy;
    ld_data  = ld_hit ? f_data : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      cmt_q      <= '0;
      tail_q     <= '0;
      cmt_err_q  <= 1'b0;
      valid_q    <= '0;
      addr_rdy_q <= '0;
      data_rdy_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rob_q[i]  <= '0;
        dtag_q[i] <= '0;
        op_q[i]   <= '0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      cmt_q     <= cmt_d;
      tail_q    <= tail_d;
      cmt_err_q <= cmt_err_q | (cmt_valid && !cmt_ok);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && !data_rdy_q[i] && cdb_valid && (dtag_q[i] == cdb_tag)) begin
          data_q[i]     <= cdb_data;
          data_rdy_q[i] <= 1'b1;
        end
        if (addr_ok && (addr_idx[PTR_W-1:0] == PTR_W'(i))) begin
          addr_q[i]     <= addr_value;
          addr_rdy_q[i] <= 1'b1;
        end
        if (do_alloc && (tail_q[PTR_W-1:0] == PTR_W'(i))) begin
          valid_q[i]    <= 1'b1;
          rob_q[i]      <= alloc_rob_id;
          op_q[i]       <= alloc_opcode;
          dtag_q[i]     <= alloc_dtag;
          addr_q[i]     <= '0;
          addr_rdy_q[i] <= 1'b0;
          data_q[i]     <= alloc_cap ? cdb_data : alloc_data;
          data_rdy_q[i] <= alloc_dfill || alloc_cap;
        end
        if ((pop && (hs == PTR_W'(i))) || kill[i]) begin
          valid_q[i]    <= 1'b0;
          addr_rdy_q[i] <= 1'b0;
          data_rdy_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_parametric_store_queue.sv
module tb_parametric_store_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid, alloc_ready, alloc_dfill;
  logic [4:0]  alloc_rob_id, alloc_dtag;
  logic [5:0]  alloc_opcode;
  logic [31:0] alloc_data;
  logic [3:0]  alloc_idx, addr_idx, ld_age, count;
  logic        addr_valid, cdb_valid, cmt_valid, flush, ld_valid;
  logic [31:0] addr_value, ld_addr, ld_data;
  logic [36:0] cdb;
  logic [4:0]  cmt_id, o_rob_id;
  logic        ld_hit, ld_stall, o_valid, o_ready, cmt_err;
  logic [5:0]  o_opcode;
  logic [31:0] o_address, o_data;

  typedef struct packed {
    logic [4:0]  rob;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int passed = 0;
  logic [3:0] tail_m = 4'd0;

  parametric_store_queue dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rob_id(alloc_rob_id),
    .alloc_opcode(alloc_opcode), .alloc_data(alloc_data), .alloc_dtag(alloc_dtag),
    .alloc_dfill(alloc_dfill), .alloc_idx(alloc_idx),
    .addr_valid(addr_valid), .addr_idx(addr_idx), .addr_value(addr_value),
    .cdb(cdb), .cdb_valid(cdb_valid), .cmt_valid(cmt_valid), .cmt_id(cmt_id), .flush(flush),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_age(ld_age), .ld_hit(ld_hit),
    .ld_data(ld_data), .ld_stall(ld_stall),
    .o_valid(o_valid), .o_rob_id(o_rob_id), .o_opcode(o_opcode), .o_address(o_address),
    .o_data(o_data), .o_ready(o_ready), .count(count), .cmt_err(cmt_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [4:0] rob, input logic [31:0] d, input logic [4:0] tag,
                       input logic fill);
    alloc_valid = 1'b1; alloc_rob_id = rob; alloc_opcode = 6'h2;
    alloc_data = d; alloc_dtag = tag; alloc_dfill = fill;
    step();
    alloc_valid = 1'b0; alloc_dfill = 1'b0;
    tail_m = tail_m + 4'd1;
  endtask

  task automatic set_addr(input logic [3:0] idx, input logic [31:0] a);
    addr_valid = 1'b1; addr_idx = idx; addr_value = a;
    step();
    addr_valid = 1'b0;
  endtask

  task automatic commit(input logic [4:0] id);
    cmt_valid = 1'b1; cmt_id = id;
    step();
    cmt_valid = 1'b0;
  endtask

  // Pops n stores from the memory port and compares each with the scoreboard front.
  task automatic drain(input int n);
    exp_t e;
    int   waited;
    o_ready = 1'b1;
    for (int j = 0; j < n; j++) begin
      waited = 0;
      #1;
      while (!o_valid && waited < 50) begin
        step();
        #1;
        waited++;
      end
      checks++;
      if (!o_valid || sb.size() == 0) begin
        $display("FAIL drain_timeout: o_valid=%0b pending=%0d", o_valid, sb.size());
      end else begin
        e = sb.pop_front();
        if ({o_rob_id, o_address, o_data} !== {e.rob, e.addr, e.data})
          $display("FAIL drain_data: got rob=%0d addr=%h data=%h want rob=%0d addr=%h data=%h",
                   o_rob_id, o_address, o_data, e.rob, e.addr, e.data);
        else passed++;
      end
      step();
    end
    o_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alloc_valid = 0; alloc_rob_id = 0; alloc_opcode = 0; alloc_data = 0; alloc_dtag = 0;
    alloc_dfill = 0; addr_valid = 0; addr_idx = 0; addr_value = 0; cdb = 0; cdb_valid = 0;
    cmt_valid = 0; cmt_id = 0; flush = 0; ld_valid = 0; ld_addr = 0; ld_age = 0; o_ready = 0;
    step(); step();
    checks++;
    if ({o_valid, ld_hit, ld_stall, cmt_err} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {o_valid, ld_hit, ld_stall, cmt_err});
    else passed++;
    checks++;
    if (count !== 4'd0 || alloc_ready !== 1'b1)
      $display("FAIL reset_count: got count=%0d ready=%0b want 0/1", count, alloc_ready);
    else passed++;
    checks++;
    if ({o_rob_id, o_opcode, o_address, o_data, ld_data} !== '0)
      $display("FAIL reset_data: got nonzero data outputs want 0");
    else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_full();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      alloc(5'(i), 32'h1000 + 32'(i), 5'd0, 1'b1);
      sb.push_back({5'(i), 32'h100 + 32'(4 * i), 32'h1000 + 32'(i)});
    end
    checks++;
    if (alloc_ready !== 1'b0 || count !== 4'd8)
      $display("FAIL full: got ready=%0b count=%0d want 0/8", alloc_ready, count);
    else passed++;
    checks++;
    if (alloc_idx !== tail_m)
      $display("FAIL full_idx: got %0d want %0d", alloc_idx, tail_m);
    else passed++;
    set_addr(4'd0, 32'h100);
    commit(5'd0);
    o_ready = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b1 || alloc_ready !== 1'b0)
      $display("FAIL pop_cycle: got valid=%0b ready=%0b want 1/0", o_valid, alloc_ready);
    else passed++;
    e = sb.pop_front();
    checks++;
    if ({o_rob_id, o_address, o_data} !== {e.rob, e.addr, e.data})
      $display("FAIL pop_data: got %0d %h %h want %0d %h %h",
               o_rob_id, o_address, o_data, e.rob, e.addr, e.data);
    else passed++;
    step();
    o_ready = 1'b0;
    checks++;
    if (alloc_ready !== 1'b1 || count !== 4'd7)
      $display("FAIL after_pop: got ready=%0b count=%0d want 1/7", alloc_ready, count);
    else passed++;
    for (int i = 1; i < 8; i++) begin
      set_addr(4'(i), 32'h100 + 32'(4 * i));
      commit(5'(i));
    end
    drain(7);
    checks++;
    if (count !== 4'd0)
      $display("FAIL full_empty: got %0d want 0", count);
    else passed++;
  endtask

  task automatic test_forward();
    logic [3:0] p;
    p = tail_m;
    alloc(5'd10, 32'h11, 5'd0, 1'b1);
    alloc(5'd11, 32'h22, 5'd0, 1'b1);
    set_addr(p, 32'h40);
    set_addr(p + 4'd1, 32'h40);
    ld_valid = 1'b1; ld_addr = 32'h40; ld_age = p + 4'd2;
    #1;
    checks++;
    if ({ld_hit, ld_stall} !== 2'b10 || ld_data !== 32'h22)
      $display("FAIL fwd_young: got hit=%0b stall=%0b data=%h want 1/0/22", ld_hit, ld_stall, ld_data);
    else passed++;
    ld_age = p + 4'd1;
    #1;
    checks++;
    if ({ld_hit, ld_stall} !== 2'b10 || ld_data !== 32'h11)
      $display("FAIL fwd_mid: got hit=%0b stall=%0b data=%h want 1/0/11", ld_hit, ld_stall, ld_data);
    else passed++;
    ld_age = p;
    #1;
    checks++;
    if ({ld_hit, ld_stall} !== 2'b00)
      $display("FAIL fwd_none_older: got hit=%0b stall=%0b want 0/0", ld_hit, ld_stall);
    else passed++;
    ld_age = p + 4'd2; ld_addr = 32'h44;
    #1;
    checks++;
    if ({ld_hit, ld_stall} !== 2'b00)
      $display("FAIL fwd_miss: got hit=%0b stall=%0b want 0/0", ld_hit, ld_stall);
    else passed++;
    ld_valid = 1'b0;
    sb.push_back({5'd10, 32'h40, 32'h11});
    sb.push_back({5'd11, 32'h40, 32'h22});
    commit(5'd10);
    commit(5'd11);
    drain(2);
  endtask

  task automatic test_stall();
    logic [3:0] p;
    p = tail_m;
    alloc(5'd12, 32'h33, 5'd0, 1'b1);
    ld_valid = 1'b1; ld_addr = 32'h10; ld_age = p + 4'd1;
    #1;
    checks++;
    if ({ld_hit, ld_stall} !== 2'b01)
      $display("FAIL stall_unres: got hit=%0b stall=%0b want 0/1", ld_hit, ld_stall);
    else passed++;
    set_addr(p ^ 4'b1000, 32'h10);  // stale wrap bit: must be dropped
    #1;
    checks++;
    if ({ld_hit, ld_stall} !== 2'b01)
      $display("FAIL stall_wrap_ignored: got hit=%0b stall=%0b want 0/1", ld_hit, ld_stall);
    else passed++;
    set_addr(p, 32'h80);
    #1;
    checks++;
    if ({ld_hit, ld_stall} !== 2'b00)
      $display("FAIL stall_resolved: got hit=%0b stall=%0b want 0/0", ld_hit, ld_stall);
    else passed++;
    ld_valid = 1'b0;
    sb.push_back({5'd12, 32'h80, 32'h33});
    commit(5'd12);
    drain(1);
  endtask

  task automatic test_cdb();
    logic [3:0] p;
    p = tail_m;
    cdb_valid = 1'b1; cdb = {5'd3, 32'hDEAD};
    alloc(5'd13, 32'h0, 5'd3, 1'b0);
    cdb_valid = 1'b0;
    set_addr(p, 32'hA0);
    sb.push_back({5'd13, 32'hA0, 32'hDEAD});
    commit(5'd13);
    drain(1);
    p = tail_m;
    alloc(5'd14, 32'h0, 5'd4, 1'b0);
    set_addr(p, 32'hB0);
    commit(5'd14);
    checks++;
    if (o_valid !== 1'b0)
      $display("FAIL cdb_wait: got o_valid=%0b want 0", o_valid);
    else passed++;
    cdb_valid = 1'b1; cdb = {5'd4, 32'hBEEF};
    step();
    cdb_valid = 1'b0;
    sb.push_back({5'd14, 32'hB0, 32'hBEEF});
    drain(1);
  endtask

  task automatic test_flush();
    logic [3:0] p;
    p = tail_m;
    for (int k = 0; k < 3; k++) begin
      alloc(5'(20 + k), 32'h200 + 32'(k), 5'd0, 1'b1);
      set_addr(p + 4'(k), 32'h300 + 32'(4 * k));
    end
    commit(5'd20);
    cmt_valid = 1'b1; cmt_id = 5'd21; flush = 1'b1;
    #1;
    checks++;
    if (alloc_ready !== 1'b0)
      $display("FAIL flush_blocks_alloc: got %0b want 0", alloc_ready);
    else passed++;
    step();
    cmt_valid = 1'b0; flush = 1'b0;
    tail_m = p + 4'd2;
    checks++;
    if (count !== 4'd2 || alloc_idx !== tail_m)
      $display("FAIL flush_count: got count=%0d idx=%0d want 2/%0d", count, alloc_idx, tail_m);
    else passed++;
    sb.push_back({5'd20, 32'h300, 32'h200});
    sb.push_back({5'd21, 32'h304, 32'h201});
    drain(2);
    checks++;
    if (count !== 4'd0 || o_valid !== 1'b0)
      $display("FAIL flush_empty: got count=%0d valid=%0b want 0/0", count, o_valid);
    else passed++;
    alloc(5'd5, 32'h77, 5'd0, 1'b1);
    commit(5'd6);
    checks++;
    if (cmt_err !== 1'b1 || count !== 4'd1)
      $display("FAIL cmt_err: got err=%0b count=%0d want 1/1", cmt_err, count);
    else passed++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    tail_m = tail_m - 4'd1;
    checks++;
    if (count !== 4'd0 || cmt_err !== 1'b1)
      $display("FAIL err_sticky: got count=%0d err=%0b want 0/1", count, cmt_err);
    else passed++;
  endtask

  task automatic test_hold();
    logic [3:0] p;
    p = tail_m;
    alloc(5'd7, 32'h55, 5'd0, 1'b1);
    set_addr(p, 32'h90);
    commit(5'd7);
    o_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({o_valid, o_rob_id, o_address, o_data} !== {1'b1, 5'd7, 32'h90, 32'h55})
        $display("FAIL hold_stable: cycle %0d got v=%0b rob=%0d a=%h d=%h want 1/7/90/55",
                 c, o_valid, o_rob_id, o_address, o_data);
      else passed++;
      step();
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({o_valid, cmt_err} !== 2'b00 || count !== 4'd0)
      $display("FAIL async_rst: got v=%0b err=%0b count=%0d want 0/0/0", o_valid, cmt_err, count);
    else passed++;
    step();
    rst = 1'b0;
    tail_m = 4'd0;
    sb.delete();
    step();
  endtask

  initial begin
    test_reset();
    test_full();
    test_forward();
    test_stall();
    test_cdb();
    test_flush();
    test_hold();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
